// File: rtl/peripheral_wb_spram_arbiter_if.sv
// Wishbone classic/registered-feedback bus bundle.
//   master modport : drives the request (adr..stb), receives ack/err/dat_r
//   slave modport  : receives the request, drives ack/err/dat_r
// dat_w carries write data from master to slave, dat_r carries read data back.
interface peripheral_wb_spram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [3:0]    sel;
  logic          we;
  logic [1:0]    bte;
  logic [2:0]    cti;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;
  logic [DW-1:0] dat_r;

  modport master (
    output adr, dat_w, sel, we, bte, cti, cyc, stb,
    input  ack, err, dat_r
  );

  modport slave (
    input  adr, dat_w, sel, we, bte, cti, cyc, stb,
    output ack, err, dat_r
  );
endinterface

// File: rtl/peripheral_wb_spram_arbiter.sv
// Two-master Wishbone arbiter in front of one single-port SPRAM slave.
//   wb_clk_i  : clock, rising edge
//   wb_rst_ni : asynchronous reset, active low
//   m0, m1    : master-side buses (slave modport, the arbiter answers them)
//   s         : slave-side bus (master modport, the arbiter drives the SPRAM)
//   gnt_o     : one-hot current owner {m1, m0}
// Round-robin with bus lock: an owner keeps the slave for as long as its cyc
// is high, then the arbiter always passes through one IDLE cycle before the
// next owner is chosen. A watchdog turns an unanswered strobe into err after
// TIMEOUT cycles and hides that last strobe from the slave.

// Per-master response steering: only the current owner sees the slave.
module peripheral_wb_spram_arbiter_rsp #(
  parameter int DW = 32
) (
  input  logic          gnt,
  input  logic          slv_ack,
  input  logic          slv_err,
  input  logic          tmo,
  input  logic [DW-1:0] slv_dat,
  output logic          ack,
  output logic          err,
  output logic [DW-1:0] dat
);
  assign ack = gnt & slv_ack;
  assign err = gnt & (slv_err | tmo);
  assign dat = gnt ? slv_dat : '0;
endmodule

module peripheral_wb_spram_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  peripheral_wb_spram_arbiter_if.slave   m0,
  peripheral_wb_spram_arbiter_if.slave   m1,
  peripheral_wb_spram_arbiter_if.master  s,
  output logic [1:0]                     gnt_o
);
  localparam int NUM_M = 2;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    logic          we;
    logic [1:0]    bte;
    logic [2:0]    cti;
    logic          cyc;
    logic          stb;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;   // previous owner, 1 = m1
  logic [CW-1:0]          cnt_q, cnt_d;

  wb_req_t [NUM_M-1:0]    req;
  wb_req_t                own;
  logic    [NUM_M-1:0]    gnt;
  logic                   busy, wd_hit, tmo;

  logic [NUM_M-1:0]           rsp_ack, rsp_err;
  logic [NUM_M-1:0][DW-1:0]   rsp_dat;

  assign req[0] = '{adr: m0.adr, dat: m0.dat_w, sel: m0.sel, we: m0.we,
                    bte: m0.bte, cti: m0.cti, cyc: m0.cyc, stb: m0.stb};
  assign req[1] = '{adr: m1.adr, dat: m1.dat_w, sel: m1.sel, we: m1.we,
                    bte: m1.bte, cti: m1.cti, cyc: m1.cyc, stb: m1.stb};

  // ---------------------------------------------------------------- state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;          // m0 wins the first tie
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Owners never hand over directly; every release goes through IDLE, which
  // is where the round-robin decision is made.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req[0].cyc && req[1].cyc) state_d = last_q ? GNT0 : GNT1;
        else if (req[0].cyc)          state_d = GNT0;
        else if (req[1].cyc)          state_d = GNT1;
      end
      GNT0: if (!req[0].cyc) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
      GNT1: if (!req[1].cyc) begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- routing
  assign gnt   = {state_q == GNT1, state_q == GNT0};
  assign gnt_o = gnt;

  always_comb begin
    own = '0;
    if (gnt[0])      own = req[0];
    else if (gnt[1]) own = req[1];
  end

  // ---------------------------------------------------------------- watchdog
  // busy: a strobe is outstanding and the slave has not answered this cycle.
  // An ack/err arriving in the deadline cycle clears busy, so a late answer
  // always beats the timeout. tmo depends combinationally on s.ack/s.err,
  // which is why the slave must not derive ack combinationally from stb.
  assign busy   = own.stb & ~s.ack & ~s.err;
  assign wd_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign tmo    = busy & wd_hit;

  always_comb begin
    cnt_d = '0;
    if (busy && !wd_hit) cnt_d = cnt_q + CW'(1);
  end

  assign s.adr   = own.adr;
  assign s.dat_w = own.dat;
  assign s.sel   = own.sel;
  assign s.we    = own.we;
  assign s.bte   = own.bte;
  assign s.cti   = own.cti;
  assign s.cyc   = own.cyc;
  assign s.stb   = own.stb & ~tmo;   // the abandoned beat never reaches the slave

  // ---------------------------------------------------------------- responses
  for (genvar i = 0; i < NUM_M; i++) begin : g_rsp
    peripheral_wb_spram_arbiter_rsp #(.DW(DW)) u_rsp (
      .gnt     (gnt[i]),
      .slv_ack (s.ack),
      .slv_err (s.err),
      .tmo     (tmo),
      .slv_dat (s.dat_r),
      .ack     (rsp_ack[i]),
      .err     (rsp_err[i]),
      .dat     (rsp_dat[i])
    );
  end

  assign m0.ack   = rsp_ack[0];
  assign m0.err   = rsp_err[0];
  assign m0.dat_r = rsp_dat[0];
  assign m1.ack   = rsp_ack[1];
  assign m1.err   = rsp_err[1];
  assign m1.dat_r = rsp_dat[1];
endmodule

// File: tb/tb_peripheral_wb_spram_arbiter.sv
module tb_peripheral_wb_spram_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gnt_o;

  peripheral_wb_spram_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  peripheral_wb_spram_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  peripheral_wb_spram_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  peripheral_wb_spram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .gnt_o     (gnt_o)
  );

  initial forever #5 clk = ~clk;

  int  n_checks = 0;
  int  n_err    = 0;
  bit  abort    = 1'b0;
  bit  slave_en = 1'b1;
  bit  slave_err = 1'b0;
  int  slave_lat = 1;

  int     gnt_own[$];
  longint gnt_t[$];

  typedef struct {
    int          acks;
    int          errs;
    int          wait_c;
    int          resp_at;
    logic [31:0] rdat;
    logic        stb_at_resp;
    longint      t_drop;
  } xres_t;

  xres_t r0, r1;
  int    a0, a1, base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_gnt(input string nm, input int idx, input int exp);
    if (idx < gnt_own.size()) chk(nm, 64'(gnt_own[idx]), 64'(exp));
    else begin
      n_checks++; n_err++;
      $display("FAIL %s got=missing want=%0d", nm, exp);
    end
  endtask

  // A new owner must appear on the 2nd cycle after the old one drops cyc.
  task automatic chk_bubble(input string nm, input int idx, input longint t_drop);
    if (idx < gnt_t.size()) chk(nm, 64'(gnt_t[idx] - t_drop), 64'd24);
    else begin
      n_checks++; n_err++;
      $display("FAIL %s got=missing want=24", nm);
    end
  endtask

  function automatic logic [2:0] cti_of(input int beat, input int beats);
    if (beats == 1)         return 3'b000;
    if (beat == beats - 1)  return 3'b111;
    return 3'b010;
  endfunction

  task automatic set_req(input int m, input logic cyc, input logic stb,
                         input logic [7:0] adr, input logic we, input logic [2:0] cti);
    logic [31:0] wd;
    wd = {8'h5A, 8'(m), 8'hC3, adr};
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.adr = adr; m0_if.we = we;
      m0_if.cti = cti; m0_if.bte = 2'b00; m0_if.sel = we ? 4'h3 : 4'hF; m0_if.dat_w = wd;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.adr = adr; m1_if.we = we;
      m1_if.cti = cti; m1_if.bte = 2'b00; m1_if.sel = we ? 4'hC : 4'hF; m1_if.dat_w = wd;
    end
  endtask

  function automatic logic m_ack(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction
  function automatic logic m_err(input int m);
    return (m == 0) ? m0_if.err : m1_if.err;
  endfunction
  function automatic logic [31:0] m_dat(input int m);
    return (m == 0) ? m0_if.dat_r : m1_if.dat_r;
  endfunction

  // One Wishbone cycle of `beats` beats; incrementing address by 4 per beat.
  task automatic master_xfer(input int m, input logic [7:0] adr0, input int beats,
                             input logic we, output xres_t r);
    int beat, guard, gcyc;
    r.acks = 0; r.errs = 0; r.wait_c = 0; r.resp_at = 0;
    r.rdat = '0; r.stb_at_resp = 1'b0; r.t_drop = 0;
    @(posedge clk); #1;
    set_req(m, 1'b1, 1'b1, adr0, we, cti_of(0, beats));
    beat = 0; guard = 0; gcyc = 0;
    while (beat < beats) begin
      @(negedge clk);
      guard++;
      if (abort) break;
      if (guard > 200) begin
        n_checks++; n_err++;
        $display("FAIL xfer_timeout m%0d got=no_response want=response", m);
        break;
      end
      if (gnt_o[m]) gcyc++;
      else if (gcyc == 0) r.wait_c++;
      if (m_ack(m)) begin
        r.acks++; r.rdat = m_dat(m);
        if (r.resp_at == 0) begin r.resp_at = gcyc; r.stb_at_resp = s_if.stb; end
        beat++;
      end else if (m_err(m)) begin
        r.errs++;
        if (r.resp_at == 0) begin r.resp_at = gcyc; r.stb_at_resp = s_if.stb; end
        beat = beats;
      end
      @(posedge clk); #1;
      if (beat < beats) set_req(m, 1'b1, 1'b1, adr0 + 8'(4 * beat), we, cti_of(beat, beats));
    end
    set_req(m, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    r.t_drop = $time;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // SPRAM stand-in: registered answer slave_lat cycles after a strobe is seen.
  initial begin : slave_model
    int pcnt;
    logic [7:0] adr_seen;
    pcnt = 0; adr_seen = '0;
    s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = 32'h0BAD_0000;
    forever begin
      @(negedge clk);
      if (s_if.cyc && s_if.stb && !s_if.ack && !s_if.err) begin
        pcnt++; adr_seen = s_if.adr;
      end else pcnt = 0;
      @(posedge clk); #1;
      s_if.ack   = slave_en && !slave_err && pcnt > 0 && pcnt >= slave_lat;
      s_if.err   = slave_en &&  slave_err && pcnt > 0 && pcnt >= slave_lat;
      s_if.dat_r = s_if.ack ? {24'hD0D0D0, adr_seen} : 32'h0BAD_0000;
    end
  end

  // Records every new owner and when it first became visible.
  initial begin : grant_monitor
    logic [1:0] prev;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (gnt_o != 2'b00 && gnt_o != prev) begin
        gnt_own.push_back(gnt_o[1] ? 1 : 0);
        gnt_t.push_back($time);
      end
      prev = gnt_o;
    end
  end

  // Behavioural reference: who owns the slave, who went last, and how many
  // consecutive cycles the owner's strobe has gone unanswered.
  int          owner_m = -1;
  int          last_m  = 1;
  int          wait_m  = 0;
  logic        o_cyc, o_stb, o_we, e_tmo, e_busy;
  logic [7:0]  o_adr;
  logic [31:0] o_dat;
  logic [3:0]  o_sel;
  logic [1:0]  o_bte, e_gnt;
  logic [2:0]  o_cti;
  logic        e0_ack, e0_err, e1_ack, e1_err;
  logic [31:0] e0_dat, e1_dat;
  logic [121:0] ev, av;

  initial begin : compare
    forever begin
      @(negedge clk);
      {o_cyc, o_stb, o_we, o_adr, o_dat, o_sel, o_bte, o_cti} = '0;
      {e_gnt, e_tmo, e_busy, e0_ack, e0_err, e1_ack, e1_err} = '0;
      e0_dat = '0; e1_dat = '0;
      if (rst_n && owner_m >= 0) begin
        if (owner_m == 0) begin
          o_cyc = m0_if.cyc; o_stb = m0_if.stb; o_we = m0_if.we; o_adr = m0_if.adr;
          o_dat = m0_if.dat_w; o_sel = m0_if.sel; o_bte = m0_if.bte; o_cti = m0_if.cti;
        end else begin
          o_cyc = m1_if.cyc; o_stb = m1_if.stb; o_we = m1_if.we; o_adr = m1_if.adr;
          o_dat = m1_if.dat_w; o_sel = m1_if.sel; o_bte = m1_if.bte; o_cti = m1_if.cti;
        end
        e_busy = o_stb && !s_if.ack && !s_if.err;
        e_tmo  = e_busy && (wait_m == TMO - 1);
        e_gnt  = (owner_m == 0) ? 2'b01 : 2'b10;
        if (owner_m == 0) begin
          e0_ack = s_if.ack; e0_err = s_if.err | e_tmo; e0_dat = s_if.dat_r;
        end else begin
          e1_ack = s_if.ack; e1_err = s_if.err | e_tmo; e1_dat = s_if.dat_r;
        end
      end
      ev = {e_gnt, o_cyc, o_stb & ~e_tmo, o_adr, o_dat, o_sel, o_we, o_bte, o_cti,
            e0_ack, e0_err, e0_dat, e1_ack, e1_err, e1_dat};
      av = {gnt_o, s_if.cyc, s_if.stb, s_if.adr, s_if.dat_w, s_if.sel, s_if.we, s_if.bte,
            s_if.cti, m0_if.ack, m0_if.err, m0_if.dat_r, m1_if.ack, m1_if.err, m1_if.dat_r};
      n_checks++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL cycle_model t=%0t got=%h want=%h", $time, av, ev);
      end
      if (!rst_n) begin
        owner_m = -1; last_m = 1; wait_m = 0;
      end else if (owner_m < 0) begin
        wait_m = 0;
        if (m0_if.cyc && m1_if.cyc) owner_m = 1 - last_m;
        else if (m0_if.cyc)         owner_m = 0;
        else if (m1_if.cyc)         owner_m = 1;
      end else begin
        wait_m = (e_busy && !e_tmo) ? wait_m + 1 : 0;
        if (!o_cyc) begin last_m = owner_m; owner_m = -1; end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    set_req(1, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    // Requests present while reset is held must not produce a grant.
    set_req(0, 1'b1, 1'b1, 8'h10, 1'b0, 3'b000);
    #2;
    chk("rst_gnt",   64'(gnt_o), 64'd0);
    chk("rst_s_cyc", 64'(s_if.cyc), 64'd0);
    chk("rst_s_stb", 64'(s_if.stb), 64'd0);
    chk("rst_m0_dat", 64'(m0_if.dat_r), 64'd0);
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single read by m0
    master_xfer(0, 8'h10, 1, 1'b0, r0);
    chk("t1_wait",  64'(r0.wait_c), 64'd1);
    chk("t1_resp",  64'(r0.resp_at), 64'd2);
    chk("t1_acks",  64'(r0.acks), 64'd1);
    chk("t1_dat",   64'(r0.rdat), 64'hD0D0D010);
    repeat (3) @(posedge clk);

    // 2: simultaneous request straight after reset
    do_reset();
    base = gnt_own.size();
    fork
      master_xfer(0, 8'h20, 1, 1'b0, r0);
      master_xfer(1, 8'h30, 1, 1'b1, r1);
    join
    chk_gnt("t2_first", base, 0);
    chk_gnt("t2_second", base + 1, 1);
    chk_bubble("t2_bubble", base + 1, r0.t_drop);
    chk("t2_m1_acks", 64'(r1.acks), 64'd1);
    repeat (3) @(posedge clk);

    // 3: eight back-to-back contending transactions alternate
    base = gnt_own.size(); a0 = 0; a1 = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          master_xfer(0, 8'h80 + 8'(i), 1, i[0], r0); a0 += r0.acks;
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          master_xfer(1, 8'hA0 + 8'(j), 1, ~j[0], r1); a1 += r1.acks;
        end
      end
    join
    for (int k = 0; k < 8; k++) chk_gnt($sformatf("t3_order%0d", k), base + k, k % 2);
    chk("t3_m0_acks", 64'(a0), 64'd4);
    chk("t3_m1_acks", 64'(a1), 64'd4);
    repeat (3) @(posedge clk);

    // 4: 4-beat burst is not split by a competing request
    base = gnt_own.size();
    fork
      master_xfer(0, 8'h40, 4, 1'b0, r0);
      begin repeat (2) @(posedge clk); master_xfer(1, 8'h50, 1, 1'b0, r1); end
    join
    chk("t4_m0_acks", 64'(r0.acks), 64'd4);
    chk("t4_last_dat", 64'(r0.rdat), 64'hD0D0D04C);
    chk_gnt("t4_first", base, 0);
    chk_gnt("t4_second", base + 1, 1);
    chk_bubble("t4_bubble", base + 1, r0.t_drop);
    chk("t4_m1_dat", 64'(r1.rdat), 64'hD0D0D050);
    repeat (3) @(posedge clk);

    // 5: watchdog, repeated to show the count restarts, then ack on deadline
    slave_en = 1'b0;
    master_xfer(1, 8'h60, 1, 1'b0, r1);
    chk("t5_errs", 64'(r1.errs), 64'd1);
    chk("t5_acks", 64'(r1.acks), 64'd0);
    chk("t5_resp", 64'(r1.resp_at), 64'd8);
    chk("t5_stb_hidden", 64'(r1.stb_at_resp), 64'd0);
    master_xfer(1, 8'h62, 1, 1'b0, r1);
    chk("t5_again_resp", 64'(r1.resp_at), 64'd8);
    slave_en = 1'b1; slave_lat = 7;
    master_xfer(1, 8'h64, 1, 1'b0, r1);
    chk("t5_ackwins_acks", 64'(r1.acks), 64'd1);
    chk("t5_ackwins_errs", 64'(r1.errs), 64'd0);
    chk("t5_ackwins_resp", 64'(r1.resp_at), 64'd8);
    slave_lat = 1; slave_err = 1'b1;
    master_xfer(0, 8'h68, 1, 1'b1, r0);
    chk("t5_slverr_errs", 64'(r0.errs), 64'd1);
    chk("t5_slverr_resp", 64'(r0.resp_at), 64'd2);
    slave_err = 1'b0;
    repeat (3) @(posedge clk);

    // 6: asynchronous reset in the middle of a burst
    fork
      master_xfer(0, 8'hC0, 4, 1'b0, r0);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("t6_pre_gnt", 64'(gnt_o), 64'd1);
        chk("t6_pre_ack", 64'(m0_if.ack), 64'd1);
        #1 abort = 1'b1; rst_n = 1'b0;
        #1;
        chk("t6_gnt",   64'(gnt_o), 64'd0);
        chk("t6_s_cyc", 64'(s_if.cyc), 64'd0);
        chk("t6_ack",   64'(m0_if.ack), 64'd0);
        chk("t6_err",   64'(m0_if.err), 64'd0);
      end
    join
    @(posedge clk); #1 rst_n = 1'b1; abort = 1'b0;
    base = gnt_own.size();
    fork
      master_xfer(0, 8'hD0, 1, 1'b0, r0);
      master_xfer(1, 8'hE0, 1, 1'b0, r1);
    join
    chk_gnt("t6_tie_first", base, 0);
    chk_gnt("t6_tie_second", base + 1, 1);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
